clk_enable_gen: RTL and testbench
=================================

// Module: clk_enable_gen
// PURPOSE
//  Multi-channel, runtime-programmable clock-enable generator. Successor to fixed
//  "always #N clk=~clk" clock generation: synthesizable and driven from one clock.
//  Per channel: a one-cycle tick strobe every N clocks, plus a toggling div_out
//  (period 2N clocks, 50% duty), used as data, never as a clock.
//  Sits next to the clock root; feeds sample-rate and slow-peripheral enables.
// PARAMETERS
//  NUM_CH       2   number of independent channels (1..16)
//  DIV_W        16  divisor width in bits
//  DEFAULT_DIV  1   divisor every channel holds after reset (1 => div_out = clk/2)
// PORTS
//  clk         in   1             single system clock, rising edge
//  rst         in   1             asynchronous, active-low reset
//  ch_en       in   NUM_CH        per-channel run enable
//  div_load    in   NUM_CH        per-channel strobe: capture div_val slice
//  div_val     in   NUM_CH*DIV_W  divisors, channel i at [i*DIV_W +: DIV_W]
//  sync_restart in  1             realign all channels (counters, div_out) together
//  tick        out  NUM_CH        registered 1-cycle strobe every N clocks
//  div_out     out  NUM_CH        registered, toggles on each tick
//  cfg_err     out  1             sticky: a divisor of 0 (or bad phase) was loaded
// BEHAVIOUR
//  - Reset (rst=0, async): tick=0, div_out=0, cfg_err=0, cnt=0, divisor=DEFAULT_DIV,
//    nothing pending, all channels CH_IDLE. Release is synchronous to clk.
//  - Per-channel FSM. CH_IDLE->CH_RUN when ch_en is sampled 1.
//    CH_RUN->CH_IDLE when ch_en is sampled 0: cnt=0, tick=0 and div_out=0 on the next edge.
//  - Counting: cnt runs 0..N-1. tick is registered high on the edge where cnt wraps.
//    The first tick follows exactly N edges after the edge that first samples ch_en=1,
//    then repeats every N edges. N=1 => tick held high, div_out toggles every clock.
//  - Divisor load: div_load[i] captures its slice into a shadow register.
//    CH_IDLE: the shadow is applied immediately.
//    CH_RUN: the shadow is applied at the next wrap (glitch-free), so the current period completes.
//    Load on the wrap cycle: the new N governs the very next period.
//    A second load before the apply point overwrites the shadow (last wins).
//  - div_val==0: stored as 1 and cfg_err set. cfg_err clears only on reset.
//  - sync_restart (all channels, priority over counting): cnt=0, div_out=0, tick=0,
//    and any pending shadow is applied immediately.
//    load + restart in the same cycle: the new value takes effect at once.
//    Idle channels stay idle.
//  - Divisor width: cnt is DIV_W bits. Max N = 2^DIV_W-1; no wrap beyond N-1.
// CONFIGURATION
//  CLKGEN_PHASE_EN defined: adds input phase_val [NUM_CH*DIV_W].
//    On sync_restart, cnt[i] preloads phase_val slice; the first tick comes after N-phase edges.
//    phase_val >= N clamps to N-1 and sets cfg_err.
//  Undefined: the port is absent and restart preloads 0.
// STRUCTURE
//  Package clk_enable_gen_pkg:
//    DIV_W default constant.
//    typedef logic [DIV_W-1:0] div_t.
//    typedef enum logic {CH_IDLE, CH_RUN} ch_state_e.
//  Sub-module clk_enable_ch: one channel (FSM, counter, shadow, tick/div_out regs).
//    Generate-instantiated NUM_CH times.
//    Top level only slices buses and ORs per-channel error bits into sticky cfg_err.
// TESTING
//  1. Reset defaults, ch_en[0]=1 -> tick[0] high every cycle, div_out[0] period 2 clk.
//     Matches the clk/clk2 pair: 10 ns clk, 20 ns div_out.
//  2. Load div 5 on ch0 while idle, enable -> first tick at edge 5, then every 5;
//     div_out period 10 clocks.
//  3. ch0 running N=4, load 7 at cnt=1 -> current period ends at 4 clocks,
//     following periods 7. Load exactly on the wrap cycle -> next period 7.
//  4. ch0 N=3, ch1 N=6, free running, pulse sync_restart -> both div_out=0.
//     Ticks coincide 3/6 edges later; ch0 tick every 3rd, ch1 every 6th.
//  5. Load div_val=0 -> cfg_err=1 and channel ticks every cycle.
//     Drop ch_en mid-period -> tick/div_out 0 next edge.
//     Assert rst mid-count -> all outputs 0 immediately, asynchronously.
//  6. CLKGEN_PHASE_EN build: N=8, phase 6, restart -> first tick 2 edges later.
//     Phase 9 -> clamped to 7, cfg_err=1.

Source files
------------

// File: rtl/clk_enable_gen_pkg.sv
// Shared types and defaults for the clk_enable_gen clock-enable generator.
// Optional phase preload is built in when CLKGEN_PHASE_EN is defined.
package clk_enable_gen_pkg;

    localparam int unsigned DIV_W = 16;

    typedef logic [DIV_W-1:0] div_t;

    typedef enum logic {
        CH_IDLE = 1'b0,
        CH_RUN  = 1'b1
    } ch_state_e;

endpackage : clk_enable_gen_pkg

// File: rtl/clk_enable_ch.sv
// One clock-enable channel: run/idle FSM, wrap counter, shadowed divisor, tick and div_out.
// With CLKGEN_PHASE_EN defined, sync_restart preloads the counter from phase_i.
module clk_enable_ch #(
    parameter int unsigned DIV_W       = clk_enable_gen_pkg::DIV_W,
    parameter int unsigned DEFAULT_DIV = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ch_en_i,
    input  logic             div_load_i,
    input  logic [DIV_W-1:0] div_val_i,
    input  logic             sync_restart_i,
`ifdef CLKGEN_PHASE_EN
    input  logic [DIV_W-1:0] phase_i,
`endif
    output logic             tick_o,
    output logic             div_out_o,
    output logic             err_o
);

    import clk_enable_gen_pkg::*;

    localparam logic [DIV_W-1:0] ONE       = DIV_W'(1);
    localparam logic [DIV_W-1:0] RESET_DIV = DIV_W'(DEFAULT_DIV);

    ch_state_e        state_q, state_d;
    logic [DIV_W-1:0] cnt_q, cnt_d;
    logic [DIV_W-1:0] div_q, div_d;
    logic [DIV_W-1:0] shadow_q, shadow_d;
    logic             pend_q, pend_d;
    logic             tick_q, tick_d;
    logic             div_out_q, div_out_d;

    logic [DIV_W-1:0] load_safe;
    logic [DIV_W-1:0] n_now;
    logic [DIV_W-1:0] phase_start;
    logic             phase_bad;
    logic             wrap;

    // A divisor of zero is meaningless; it is replaced by one and flagged.
    assign load_safe = (div_val_i == '0) ? ONE : div_val_i;
    assign wrap      = (cnt_q == div_q - ONE);

    // Divisor in force if it were applied this cycle: a fresh load beats a pending shadow.
    always_comb begin
        n_now = div_q;
        if (div_load_i) begin
            n_now = load_safe;
        end else if (pend_q) begin
            n_now = shadow_q;
        end
    end

`ifdef CLKGEN_PHASE_EN
    always_comb begin
        phase_start = phase_i;
        phase_bad   = 1'b0;
        if (phase_i >= n_now) begin
            phase_start = n_now - ONE;
            phase_bad   = 1'b1;
        end
    end
`else
    assign phase_start = '0;
    assign phase_bad   = 1'b0;
`endif

    always_comb begin
        // NOTE: every variable gets its hold value first so no path through the
        // case/if tree can leave one unassigned and infer a latch.
        state_d   = state_q;
        cnt_d     = cnt_q;
        div_d     = div_q;
        shadow_d  = shadow_q;
        pend_d    = pend_q;
        tick_d    = 1'b0;
        div_out_d = div_out_q;
        err_o     = div_load_i && (div_val_i == '0);

        unique case (state_q)
            CH_IDLE: begin
                cnt_d     = '0;
                div_out_d = 1'b0;
                pend_d    = 1'b0;
                if (div_load_i) begin
                    div_d = load_safe;
                end
                if (ch_en_i && !sync_restart_i) begin
                    state_d = CH_RUN;
                end
            end

            CH_RUN: begin
                if (!ch_en_i) begin
                    state_d   = CH_IDLE;
                    cnt_d     = '0;
                    div_out_d = 1'b0;
                    div_d     = n_now;
                    pend_d    = 1'b0;
                end else if (sync_restart_i) begin
                    cnt_d     = phase_start;
                    div_out_d = 1'b0;
                    div_d     = n_now;
                    pend_d    = 1'b0;
                    err_o     = err_o || phase_bad;
                end else if (wrap) begin
                    // Shadow is only applied here, so a running period is never cut short.
                    cnt_d     = '0;
                    tick_d    = 1'b1;
                    div_out_d = ~div_out_q;
                    div_d     = n_now;
                    pend_d    = 1'b0;
                end else begin
                    cnt_d = cnt_q + ONE;
                    if (div_load_i) begin
                        shadow_d = load_safe;
                        pend_d   = 1'b1;
                    end
                end
            end

            default: begin
                state_d = CH_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= CH_IDLE;
            cnt_q     <= '0;
            div_q     <= RESET_DIV;
            shadow_q  <= RESET_DIV;
            pend_q    <= 1'b0;
            tick_q    <= 1'b0;
            div_out_q <= 1'b0;
        end else begin
            // NOTE: non-blocking updates make every register see the pre-edge
            // values, so ordering inside this block cannot change behaviour.
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            div_q     <= div_d;
            shadow_q  <= shadow_d;
            pend_q    <= pend_d;
            tick_q    <= tick_d;
            div_out_q <= div_out_d;
        end
    end

    assign tick_o    = tick_q;
    assign div_out_o = div_out_q;

endmodule : clk_enable_ch

// File: rtl/clk_enable_gen.sv
// Multi-channel runtime-programmable clock-enable generator; ticks and div_out are data, not clocks.
// Define CLKGEN_PHASE_EN to add the phase_val port used by sync_restart.
module clk_enable_gen #(
    parameter int unsigned NUM_CH      = 2,
    parameter int unsigned DIV_W       = clk_enable_gen_pkg::DIV_W,
    parameter int unsigned DEFAULT_DIV = 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NUM_CH-1:0]       ch_en,
    input  logic [NUM_CH-1:0]       div_load,
    input  logic [NUM_CH*DIV_W-1:0] div_val,
    input  logic                    sync_restart,
`ifdef CLKGEN_PHASE_EN
    input  logic [NUM_CH*DIV_W-1:0] phase_val,
`endif
    output logic [NUM_CH-1:0]       tick,
    output logic [NUM_CH-1:0]       div_out,
    output logic                    cfg_err
);

    import clk_enable_gen_pkg::*;

    logic [NUM_CH-1:0] ch_err;
    logic              cfg_err_q;

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        clk_enable_ch #(
            .DIV_W       (DIV_W),
            .DEFAULT_DIV (DEFAULT_DIV)
        ) u_ch (
            .clk            (clk),
            .rst            (rst),
            .ch_en_i        (ch_en[i]),
            .div_load_i     (div_load[i]),
            .div_val_i      (div_val[i*DIV_W +: DIV_W]),
            .sync_restart_i (sync_restart),
`ifdef CLKGEN_PHASE_EN
            .phase_i        (phase_val[i*DIV_W +: DIV_W]),
`endif
            .tick_o         (tick[i]),
            .div_out_o      (div_out[i]),
            .err_o          (ch_err[i])
        );
    end

    // Sticky until reset: software reads it long after the offending load.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cfg_err_q <= 1'b0;
        end else if (|ch_err) begin
            cfg_err_q <= 1'b1;
        end
    end

    assign cfg_err = cfg_err_q;

endmodule : clk_enable_gen

// File: tb/tb_clk_enable_gen.sv
// Self-checking bench for clk_enable_gen: directed scenarios then random traffic,
// every cycle compared against an event-time reference model.
module tb_clk_enable_gen;

    import clk_enable_gen_pkg::*;

    localparam int NUM_CH  = 2;
    localparam int DW      = 16;
    localparam int DEF_DIV = 1;

    logic                 clk = 1'b0;
    logic                 rst = 1'b0;
    logic [NUM_CH-1:0]    ch_en = '0;
    logic [NUM_CH-1:0]    div_load = '0;
    logic [NUM_CH*DW-1:0] div_val = '0;
    logic                 sync_restart = 1'b0;
`ifdef CLKGEN_PHASE_EN
    logic [NUM_CH*DW-1:0] phase_val = '0;
`endif
    logic [NUM_CH-1:0]    tick;
    logic [NUM_CH-1:0]    div_out;
    logic                 cfg_err;

    always #5 clk = ~clk;

    clk_enable_gen #(
        .NUM_CH      (NUM_CH),
        .DIV_W       (DW),
        .DEFAULT_DIV (DEF_DIV)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .ch_en        (ch_en),
        .div_load     (div_load),
        .div_val      (div_val),
        .sync_restart (sync_restart),
`ifdef CLKGEN_PHASE_EN
        .phase_val    (phase_val),
`endif
        .tick         (tick),
        .div_out      (div_out),
        .cfg_err      (cfg_err)
    );

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: tracks the absolute edge number of each channel's next tick.
    int k = 0;
    bit m_run    [NUM_CH];
    int m_n      [NUM_CH];
    bit m_pend   [NUM_CH];
    int m_shadow [NUM_CH];
    int m_next   [NUM_CH];
    bit m_tick   [NUM_CH];
    bit m_dout   [NUM_CH];
    bit m_err;

    function automatic void model_reset();
        for (int i = 0; i < NUM_CH; i++) begin
            m_run[i]    = 1'b0;
            m_n[i]      = DEF_DIV;
            m_pend[i]   = 1'b0;
            m_shadow[i] = DEF_DIV;
            m_next[i]   = 0;
            m_tick[i]   = 1'b0;
            m_dout[i]   = 1'b0;
        end
        m_err = 1'b0;
    endfunction

    function automatic void model_edge();
        bit en;
        bit ld;
        int v;
        int lv;
        int eff;
        int ph;
        k++;
        if (!rst) return;
        for (int i = 0; i < NUM_CH; i++) begin
            en  = ch_en[i];
            ld  = div_load[i];
            v   = int'(div_val[i*DW +: DW]);
            lv  = (v == 0) ? 1 : v;
            eff = ld ? lv : (m_pend[i] ? m_shadow[i] : m_n[i]);
            ph  = 0;
`ifdef CLKGEN_PHASE_EN
            ph  = int'(phase_val[i*DW +: DW]);
`endif
            if (ld && v == 0) m_err = 1'b1;
            m_tick[i] = 1'b0;
            if (!m_run[i]) begin
                m_dout[i] = 1'b0;
                if (ld) m_n[i] = lv;
                if (en && !sync_restart) begin
                    m_run[i]  = 1'b1;
                    m_next[i] = k + m_n[i];
                end
            end else if (!en) begin
                m_run[i]  = 1'b0;
                m_dout[i] = 1'b0;
                m_n[i]    = eff;
                m_pend[i] = 1'b0;
            end else if (sync_restart) begin
                m_n[i]    = eff;
                m_pend[i] = 1'b0;
                m_dout[i] = 1'b0;
                if (ph >= m_n[i]) begin
                    ph    = m_n[i] - 1;
                    m_err = 1'b1;
                end
                m_next[i] = k + m_n[i] - ph;
            end else if (k == m_next[i]) begin
                m_tick[i] = 1'b1;
                m_dout[i] = ~m_dout[i];
                m_n[i]    = eff;
                m_pend[i] = 1'b0;
                m_next[i] = k + m_n[i];
            end else if (ld) begin
                m_shadow[i] = lv;
                m_pend[i]   = 1'b1;
            end
        end
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h at edge %0d", tag, obs, exp, k);
        end
    endtask

    task automatic compare_all(input string tag);
        logic [NUM_CH-1:0] et;
        logic [NUM_CH-1:0] ed;
        for (int i = 0; i < NUM_CH; i++) begin
            et[i] = m_tick[i];
            ed[i] = m_dout[i];
        end
        check({tag, ".tick"},    32'(tick),    32'(et));
        check({tag, ".div_out"}, 32'(div_out), 32'(ed));
        check({tag, ".cfg_err"}, 32'(cfg_err), 32'(m_err));
    endtask

    task automatic step(input string tag);
        @(posedge clk);
        model_edge();
        #1;
        compare_all(tag);
    endtask

    task automatic run(input string tag, input int n);
        for (int c = 0; c < n; c++) step(tag);
    endtask

    task automatic load(input int ch, input div_t v);
        div_val[ch*DW +: DW] = v;
        div_load[ch]         = 1'b1;
    endtask

    task automatic clear_pulses();
        div_load     = '0;
        sync_restart = 1'b0;
    endtask

    task automatic async_reset(input string tag);
        #2;
        rst = 1'b0;
        #1;
        model_reset();
        compare_all(tag);
        run(tag, 2);
        rst = 1'b1;
    endtask

    initial begin
        bit found;
        model_reset();
        #1;
        compare_all("reset");
        run("reset_hold", 2);
        rst = 1'b1;

        // Default divisor 1: tick every cycle, div_out at clk/2.
        ch_en = 2'b01;
        run("t1_div1", 10);
        ch_en = 2'b00;
        run("t1_off", 2);

        // Idle load of 5, then enable.
        load(0, 16'd5);
        step("t2_load");
        clear_pulses();
        ch_en = 2'b01;
        run("t2_div5", 24);

        // Running at 4, load 7 mid-period, then load 8 exactly on a wrap cycle.
        ch_en = 2'b00;
        load(0, 16'd4);
        step("t3_idle");
        clear_pulses();
        ch_en = 2'b01;
        run("t3_div4", 2);
        load(0, 16'd7);
        step("t3_load7");
        clear_pulses();
        run("t3_div7", 16);
        found = 1'b0;
        for (int c = 0; c < 20 && !found; c++) begin
            if (m_next[0] == k + 1) found = 1'b1;
            else step("t3_seek");
        end
        check("t3_wrap_found", 32'(found), 32'd1);
        load(0, 16'd8);
        step("t3_wrapload");
        clear_pulses();
        run("t3_div8", 20);

        // Two channels at 3 and 6, realigned by sync_restart.
        ch_en = 2'b00;
        load(0, 16'd3);
        load(1, 16'd6);
        step("t4_idle");
        clear_pulses();
        ch_en = 2'b11;
        run("t4_free", 7);
        sync_restart = 1'b1;
        step("t4_restart");
        clear_pulses();
        run("t4_aligned", 14);

        // Zero divisor, mid-period disable, asynchronous reset.
        load(0, 16'd0);
        step("t5_zero");
        clear_pulses();
        run("t5_div1", 6);
        run("t5_mid", 2);
        ch_en = 2'b01;
        run("t5_drop", 3);
        ch_en = 2'b11;
        run("t5_count", 4);
        async_reset("t5_async");

`ifdef CLKGEN_PHASE_EN
        // Phase preload on restart, then an out-of-range phase.
        load(0, 16'd8);
        step("t6_idle");
        clear_pulses();
        ch_en = 2'b01;
        run("t6_run", 5);
        phase_val[0 +: DW] = 16'd6;
        sync_restart = 1'b1;
        step("t6_restart6");
        clear_pulses();
        run("t6_phase6", 12);
        phase_val[0 +: DW] = 16'd9;
        sync_restart = 1'b1;
        step("t6_restart9");
        clear_pulses();
        run("t6_phase9", 10);
        async_reset("t6_reset");
`endif

        // Random traffic.
        ch_en = 2'b11;
        for (int c = 0; c < 800; c++) begin
            for (int i = 0; i < NUM_CH; i++) begin
                if ($urandom_range(99) < 4) ch_en[i] = ~ch_en[i];
                if ($urandom_range(99) < 8) load(i, div_t'($urandom_range(9)));
`ifdef CLKGEN_PHASE_EN
                phase_val[i*DW +: DW] = div_t'($urandom_range(10));
`endif
            end
            sync_restart = ($urandom_range(99) < 3);
            step("rand");
            clear_pulses();
        end
        async_reset("final_reset");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule : tb_clk_enable_gen
